vga_timing_gen: RTL and testbench

//  Generates 640x480@60 VGA raster timing from the 25 MHz pixel clock. Drives DrawX/DrawY/blank into
//  the sprite/map renderers and hs/vs to the DAC/connector. Optionally delays hs/vs to line up with
//  the renderers' one-cycle registered RGB output.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_sync_delay.sv | 26 ++
 rtl/vga_timing_gen.sv | 183 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared phase type, coordinate type and default 640x480@60 timing for the VGA raster generator.
package vga_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } vga_phase_t;

  typedef logic [9:0] coord_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_COORD_LIMIT = 1024;

  // Phase a counter position belongs to, used to cross-check the phase registers.
  function automatic vga_phase_t phase_of(input int pos, input int act, input int fp,
                                          input int sync);
    vga_phase_t ph;
    if (pos < act) ph = PH_ACTIVE;
    else if (pos < act + fp) ph = PH_FRONT;
    else if (pos < act + fp + sync) ph = PH_SYNC;
    else ph = PH_BACK;
    return ph;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register that delays the {vs,hs} pair; resets every stage to the idle level.
module vga_sync_delay #(
  parameter int         DEPTH = 1,
  parameter logic [1:0] IDLE  = 2'b11
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);

  logic [1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= IDLE;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered decode of position, blank, syncs and frame pulse.
// Define VGA_SYNC_DELAY_EN to delay hs/vs by PIPE_DELAY enabled cycles behind DrawX/DrawY/blank.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit SYNC_ACT   = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        enable,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int   H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic SYNC_IDLE = ~SYNC_ACT;

  // Last position of each phase; the phase changes on the edge leaving it.
  localparam coord_t X_END_ACT   = coord_t'(H_ACTIVE - 1);
  localparam coord_t X_END_FRONT = coord_t'(H_ACTIVE + H_FP - 1);
  localparam coord_t X_END_SYNC  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t X_LAST      = coord_t'(H_TOT - 1);
  localparam coord_t Y_END_ACT   = coord_t'(V_ACTIVE - 1);
  localparam coord_t Y_END_FRONT = coord_t'(V_ACTIVE + V_FP - 1);
  localparam coord_t Y_END_SYNC  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam coord_t Y_LAST      = coord_t'(V_TOT - 1);

  if (H_TOT > VGA_COORD_LIMIT || V_TOT > VGA_COORD_LIMIT) begin : g_chk_tot
    $error("vga_timing_gen: H_TOT/V_TOT exceed the 10-bit coordinate range");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
  begin : g_chk_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end
  if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_chk_delay
    $error("vga_timing_gen: PIPE_DELAY must be in 1..4");
  end

  coord_t      cnt_x_q, cnt_x_d;
  coord_t      cnt_y_q, cnt_y_d;
  logic [15:0] fc_q, fc_d;
  logic        x_wrap, y_wrap;

  vga_phase_t  h_ph_q, h_ph_d;
  vga_phase_t  v_ph_q, v_ph_d;

  coord_t      draw_x_q, draw_y_q;
  logic        blank_q, blank_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        fs_q, fs_d;
  logic [15:0] frame_count_q;

  // Raster counters
  always_comb begin
    x_wrap  = (cnt_x_q == X_LAST);
    y_wrap  = (cnt_y_q == Y_LAST);
    cnt_x_d = x_wrap ? '0 : cnt_x_q + 10'd1;
    cnt_y_d = cnt_y_q;
    fc_d    = fc_q;
    if (x_wrap) begin
      cnt_y_d = y_wrap ? '0 : cnt_y_q + 10'd1;
      if (y_wrap) fc_d = fc_q + 16'd1;
    end
  end

  // Phase FSMs, next state
  always_comb begin
    h_ph_d = h_ph_q;
    case (h_ph_q)
      PH_ACTIVE: if (cnt_x_q == X_END_ACT)   h_ph_d = PH_FRONT;
      PH_FRONT:  if (cnt_x_q == X_END_FRONT) h_ph_d = PH_SYNC;
      PH_SYNC:   if (cnt_x_q == X_END_SYNC)  h_ph_d = PH_BACK;
      PH_BACK:   if (x_wrap)                 h_ph_d = PH_ACTIVE;
      default:                               h_ph_d = PH_ACTIVE;
    endcase
  end

  always_comb begin
    v_ph_d = v_ph_q;
    if (x_wrap) begin
      case (v_ph_q)
        PH_ACTIVE: if (cnt_y_q == Y_END_ACT)   v_ph_d = PH_FRONT;
        PH_FRONT:  if (cnt_y_q == Y_END_FRONT) v_ph_d = PH_SYNC;
        PH_SYNC:   if (cnt_y_q == Y_END_SYNC)  v_ph_d = PH_BACK;
        PH_BACK:   if (y_wrap)                 v_ph_d = PH_ACTIVE;
        default:                               v_ph_d = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      h_ph_q <= PH_ACTIVE;
      v_ph_q <= PH_ACTIVE;
    end else if (enable) begin
      h_ph_q <= h_ph_d;
      v_ph_q <= v_ph_d;
    end
  end

  // Output decode from the current counter/phase state
  always_comb begin
    blank_d = (h_ph_q == PH_ACTIVE) && (v_ph_q == PH_ACTIVE);
    hs_d    = (h_ph_q == PH_SYNC) ? SYNC_ACT : SYNC_IDLE;
    vs_d    = (v_ph_q == PH_SYNC) ? SYNC_ACT : SYNC_IDLE;
    fs_d    = (cnt_x_q == '0) && (cnt_y_q == '0);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      cnt_x_q       <= '0;
      cnt_y_q       <= '0;
      fc_q          <= '0;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      blank_q       <= 1'b0;
      hs_q          <= SYNC_IDLE;
      vs_q          <= SYNC_IDLE;
      fs_q          <= 1'b0;
      frame_count_q <= '0;
    end else if (enable) begin
      cnt_x_q       <= cnt_x_d;
      cnt_y_q       <= cnt_y_d;
      fc_q          <= fc_d;
      draw_x_q      <= cnt_x_q;
      draw_y_q      <= cnt_y_q;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      fs_q          <= fs_d;
      frame_count_q <= fc_q;
    end
  end

  assign DrawX       = draw_x_q;
  assign DrawY       = draw_y_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;
  assign frame_count = frame_count_q;

`ifdef VGA_SYNC_DELAY_EN
  logic [1:0] sync_dly;

  vga_sync_delay #(
    .DEPTH (PIPE_DELAY),
    .IDLE  ({SYNC_IDLE, SYNC_IDLE})
  ) u_sync_delay (
    .clk_i (vga_clk),
    .rst_i (reset),
    .en_i  (enable),
    .d_i   ({vs_q, hs_q}),
    .q_o   (sync_dly)
  );

  assign hs = sync_dly[0];
  assign vs = sync_dly[1];
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

  a_h_phase: assert property (@(posedge vga_clk) disable iff (reset)
    h_ph_q == phase_of(int'(cnt_x_q), H_ACTIVE, H_FP, H_SYNC));
  a_v_phase: assert property (@(posedge vga_clk) disable iff (reset)
    v_ph_q == phase_of(int'(cnt_y_q), V_ACTIVE, V_FP, V_SYNC));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: full 640x480 instance plus a reduced-timing, active-high-sync instance.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst_b = 1'b1, en_b = 1'b0, rst_s = 1'b1, en_s = 1'b0;
  logic [9:0]  x_b, y_b, x_s, y_s;
  logic        blank_b, hs_b, vs_b, fs_b, blank_s, hs_s, vs_s, fs_s;
  logic [15:0] fc_b, fc_s;
  obs_t        ob_b, ob_s;
  longint      n_b = 0, n_s = 0;
  int          checks = 0, errors = 0;

  vga_timing_gen #(.PIPE_DELAY(2)) dut (
    .vga_clk(clk), .reset(rst_b), .enable(en_b), .DrawX(x_b), .DrawY(y_b), .blank(blank_b),
    .hs(hs_b), .vs(vs_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_ACT(1'b1), .PIPE_DELAY(2)
  ) dut_s (
    .vga_clk(clk), .reset(rst_s), .enable(en_s), .DrawX(x_s), .DrawY(y_s), .blank(blank_s),
    .hs(hs_s), .vs(vs_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  assign ob_b = {x_b, y_b, blank_b, hs_b, vs_b, fs_b, fc_b};
  assign ob_s = {x_s, y_s, blank_s, hs_s, vs_s, fs_s, fc_s};

  // Enabled edges seen since the last reset
  always @(posedge clk or posedge rst_b) if (rst_b) n_b <= 0; else if (en_b) n_b <= n_b + 1;
  always @(posedge clk or posedge rst_s) if (rst_s) n_s <= 0; else if (en_s) n_s <= n_s + 1;

  // Expected outputs after n enabled edges: position k = n-1 in raster order, syncs from k-DLY.
  function automatic obs_t model(input longint n, input bit sm);
    longint ha, hf, hw, ht, va, vf, vw, vt, k, x, y;
    logic   sa;
    obs_t   o;
    if (sm) begin
      ha = 8;   hf = 2;  hw = 2;  ht = 14;  va = 4;   vf = 1;  vw = 1; vt = 7;   sa = 1'b1;
    end else begin
      ha = 640; hf = 16; hw = 96; ht = 800; va = 480; vf = 10; vw = 2; vt = 525; sa = 1'b0;
    end
    o.x = '0; o.y = '0; o.blank = 1'b0; o.hs = ~sa; o.vs = ~sa; o.fs = 1'b0; o.fc = '0;
    if (n >= 1) begin
      k = n - 1;
      x = k % ht;
      y = (k / ht) % vt;
      o.x     = 10'(x);
      o.y     = 10'(y);
      o.blank = (x < ha) && (y < va);
      o.fs    = (x == 0) && (y == 0);
      o.fc    = 16'((k / (ht * vt)) % 65536);
    end
    if (n - DLY >= 1) begin
      k = n - 1 - DLY;
      x = k % ht;
      y = (k / ht) % vt;
      o.hs = (x >= ha + hf && x < ha + hf + hw) ? sa : ~sa;
      o.vs = (y >= va + vf && y < va + vf + vw) ? sa : ~sa;
    end
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("(x=%0d y=%0d blank=%0b hs=%0b vs=%0b fs=%0b fc=%0d)",
                     o.x, o.y, o.blank, o.hs, o.vs, o.fs, o.fc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart_big();
    rst_b = 1'b1; en_b = 1'b1;
    tick();
    rst_b = 1'b0;
  endtask

  task automatic test_reset();
    obs_t rb, rs;
    rb = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    rs = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    rst_b = 1'b1; rst_s = 1'b1; en_b = 1'b1; en_s = 1'b1;
    repeat (3) tick();
    checks++;
    if (ob_b !== rb) begin errors++; $display("FAIL reset_big got %s exp %s", fmt(ob_b), fmt(rb)); end
    checks++;
    if (ob_s !== rs) begin errors++; $display("FAIL reset_small got %s exp %s", fmt(ob_s), fmt(rs)); end
    rst_b = 1'b0; rst_s = 1'b0;
    tick();
    rb = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0};
    rs = {10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
    checks++;
    if (ob_b !== rb) begin errors++; $display("FAIL first_big got %s exp %s", fmt(ob_b), fmt(rb)); end
    checks++;
    if (ob_s !== rs) begin errors++; $display("FAIL first_small got %s exp %s", fmt(ob_s), fmt(rs)); end
    en_s = 1'b0;
  endtask

  task automatic test_random_big();
    obs_t e;
    restart_big();
    for (int i = 0; i < 2500; i++) begin
      en_b = ($urandom_range(0, 3) != 0);
      tick();
      e = model(n_b, 1'b0);
      checks++;
      if (ob_b !== e) begin
        errors++;
        $display("FAIL random_big n=%0d got %s exp %s", n_b, fmt(ob_b), fmt(e));
      end
    end
  endtask

  task automatic test_boundaries();
    restart_big();
    repeat (640) tick();
    checks++;
    if (x_b !== 10'd639 || blank_b !== 1'b1) begin
      errors++; $display("FAIL blank_last_visible got x=%0d blank=%0b exp x=639 blank=1", x_b, blank_b);
    end
    tick();
    checks++;
    if (x_b !== 10'd640 || blank_b !== 1'b0) begin
      errors++; $display("FAIL blank_fall got x=%0d blank=%0b exp x=640 blank=0", x_b, blank_b);
    end
    repeat (16) tick();
    checks++;
    if (x_b !== 10'd656 || hs_b !== ((DLY == 0) ? 1'b0 : 1'b1)) begin
      errors++; $display("FAIL hs_at_656 got x=%0d hs=%0b", x_b, hs_b);
    end
    repeat (DLY) tick();
    checks++;
    if (hs_b !== 1'b0) begin
      errors++; $display("FAIL hs_start_delayed got hs=%0b exp 0 (delay %0d)", hs_b, DLY);
    end
    repeat (800 - 657 - DLY) tick();
    checks++;
    if (x_b !== 10'd799 || y_b !== 10'd0) begin
      errors++; $display("FAIL line_end got (%0d,%0d) exp (799,0)", x_b, y_b);
    end
    tick();
    checks++;
    if (x_b !== 10'd0 || y_b !== 10'd1 || blank_b !== 1'b1 || fs_b !== 1'b0) begin
      errors++; $display("FAIL line_wrap got %s exp (0,1) blank=1 fs=0", fmt(ob_b));
    end
  endtask

  task automatic test_freeze();
    obs_t snap, e;
    restart_big();
    repeat (1121) tick();
    checks++;
    if (x_b !== 10'd320 || y_b !== 10'd1) begin
      errors++; $display("FAIL freeze_pos got (%0d,%0d) exp (320,1)", x_b, y_b);
    end
    snap = ob_b;
    en_b = 1'b0;
    repeat (37) begin
      tick();
      checks++;
      if (ob_b !== snap) begin errors++; $display("FAIL freeze_hold got %s exp %s", fmt(ob_b), fmt(snap)); end
    end
    en_b = 1'b1;
    tick();
    e = model(n_b, 1'b0);
    checks++;
    if (x_b !== 10'd321 || y_b !== 10'd1 || ob_b !== e) begin
      errors++; $display("FAIL freeze_resume got %s exp %s", fmt(ob_b), fmt(e));
    end
  endtask

  task automatic test_reset_midline();
    obs_t rb, e;
    rb = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    restart_big();
    repeat (1501) tick();
    checks++;
    if (x_b !== 10'd700 || hs_b !== 1'b0) begin
      errors++; $display("FAIL midsync_pos got x=%0d hs=%0b exp x=700 hs=0", x_b, hs_b);
    end
    #5 rst_b = 1'b1;
    #1;
    checks++;
    if (ob_b !== rb) begin errors++; $display("FAIL async_reset got %s exp %s", fmt(ob_b), fmt(rb)); end
    tick();
    rst_b = 1'b0;
    for (int i = 0; i < 760; i++) begin
      tick();
      e = model(n_b, 1'b0);
      checks++;
      if (ob_b !== e) begin
        errors++; $display("FAIL after_reset n=%0d got %s exp %s", n_b, fmt(ob_b), fmt(e));
      end
    end
  endtask

  task automatic test_small_frame();
    int nb, nh, nv, nf;
    obs_t e;
    en_b = 1'b0;
    rst_s = 1'b1; en_s = 1'b1;
    tick();
    rst_s = 1'b0;
    nb = 0; nh = 0; nv = 0; nf = 0;
    for (int i = 0; i < 98; i++) begin
      tick();
      e = model(n_s, 1'b1);
      checks++;
      if (ob_s !== e) begin
        errors++; $display("FAIL small_frame n=%0d got %s exp %s", n_s, fmt(ob_s), fmt(e));
      end
      nb += int'(blank_s); nh += int'(hs_s); nv += int'(vs_s); nf += int'(fs_s);
    end
    checks++;
    if (nb != 32 || nh != 14 || nv != 14 || nf != 1) begin
      errors++;
      $display("FAIL small_counts got blank=%0d hs=%0d vs=%0d fs=%0d exp 32 14 14 1", nb, nh, nv, nf);
    end
    checks++;
    if (x_s !== 10'd13 || y_s !== 10'd6 || fc_s !== 16'd0) begin
      errors++; $display("FAIL small_last got %s exp (13,6) fc=0", fmt(ob_s));
    end
    tick();
    checks++;
    if (x_s !== 10'd0 || y_s !== 10'd0 || fs_s !== 1'b1 || fc_s !== 16'd1 || blank_s !== 1'b1) begin
      errors++; $display("FAIL small_wrap got %s exp (0,0) fs=1 fc=1 blank=1", fmt(ob_s));
    end
  endtask

  task automatic test_random_small();
    obs_t e;
    for (int i = 0; i < 700; i++) begin
      en_s = ($urandom_range(0, 4) != 0);
      tick();
      e = model(n_s, 1'b1);
      checks++;
      if (ob_s !== e) begin
        errors++; $display("FAIL random_small n=%0d got %s exp %s", n_s, fmt(ob_s), fmt(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_random_big();
    test_boundaries();
    test_freeze();
    test_reset_midline();
    test_small_frame();
    test_random_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
